// File: rtl/falafel_pkg.sv
// -----------------------------------------------------------------------------
// falafel_pkg
//   Shared definitions for the falafel allocator configuration register bank:
//   register map offsets, STATUS bit layout and decoded request/response types.
//   The COMMIT and STATUS indices sit directly after the last config register,
//   so they are expressed as offsets added to NUM_REGS by the users.
// -----------------------------------------------------------------------------
package falafel_pkg;

  // Register-map offsets relative to NUM_REGS.
  localparam int CFG_COMMIT_IDX = 0;
  localparam int CFG_STATUS_IDX = 1;

  // STATUS word layout.
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_PARITY_BIT  = 1;
  localparam int STATUS_COUNT_LSB   = 8;

  // Which register an access lands on after address decode.
  typedef enum logic [1:0] {
    TGT_CFG    = 2'd0,
    TGT_COMMIT = 2'd1,
    TGT_STATUS = 2'd2,
    TGT_NONE   = 2'd3
  } cfg_target_e;

  // Decoded request (data/strobe stay on their own, width-parametric buses).
  typedef struct packed {
    logic        we;
    cfg_target_e target;
    logic        err;
  } cfg_req_t;

  // Registered response control (read data held separately).
  typedef struct packed {
    logic valid;
    logic err;
  } cfg_rsp_t;

endpackage

// File: rtl/falafel_cfg_commit_ctrl.sv
// -----------------------------------------------------------------------------
// falafel_cfg_commit_ctrl
//   Commit sequencing for the config bank. A COMMIT request is applied at once
//   when the core is idle, otherwise it is remembered as pending and applied on
//   the first idle cycle. Repeated COMMITs while pending coalesce into a single
//   apply. Every apply bumps a wrapping counter and produces a one-cycle
//   commit pulse in the following cycle.
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   commit_req_i   accepted, error-free write to COMMIT this cycle
//   busy_i         core mid-operation; defers the apply
//   apply_o        combinational: copy shadow to active on this edge
//   pending_o      a deferred commit is waiting
//   count_o        number of applies performed (wraps)
//   commit_o       one-cycle pulse the cycle after an apply
// -----------------------------------------------------------------------------
module falafel_cfg_commit_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             commit_req_i,
  input  logic             busy_i,
  output logic             apply_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] count_o,
  output logic             commit_o
);

  logic             pending_q;
  logic [CNT_W-1:0] count_q;
  logic             commit_q;

  // A fresh request and a pending one are treated alike, which is what
  // coalesces multiple deferred COMMITs into one apply.
  always_comb begin
    apply_o = (commit_req_i || pending_q) && !busy_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      count_q   <= '0;
      commit_q  <= 1'b0;
    end else begin
      if (apply_o) begin
        pending_q <= 1'b0;
      end else if (commit_req_i) begin
        pending_q <= 1'b1;
      end
      if (apply_o) begin
        count_q <= count_q + CNT_W'(1);
      end
      commit_q <= apply_o;
    end
  end

  assign pending_o = pending_q;
  assign count_o   = count_q;
  assign commit_o  = commit_q;

endmodule

// File: rtl/falafel_config_regfile.sv
// -----------------------------------------------------------------------------
// falafel_config_regfile
//   Parametrised configuration register bank for the falafel allocator.
//   The host writes NUM_REGS shadow registers over a valid/ready request
//   channel with byte strobes; a write to COMMIT copies all shadow registers
//   to the active set atomically (deferred while busy_i). The active set
//   drives cfg_o: entries 0/1/2 are free_list_ptr/lock_ptr/lock_id.
//   Register map (index = byte address / (DATA_W/8)):
//     0..NUM_REGS-1  config (rw, reads return shadow)
//     NUM_REGS       COMMIT (wo, reads 0)
//     NUM_REGS+1     STATUS (ro): [0] pending, [1] parity error,
//                    [8 +: CNT_W] applied-commit count
//   Optional feature macro: FALAFEL_CFG_PARITY_EN adds an even-parity bit per
//   active register, a sticky error in STATUS[1] and the parity_err_o port.
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o    request handshake (one outstanding request)
//   req_we_i, req_addr_i         write enable, byte address
//   req_wdata_i, req_wstrb_i     write data, byte enables
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_err_o       read data (0 for writes/errors), error flag
//   busy_i                       core mid-operation; defers commit
//   cfg_o                        active registers, entry i at [i*DATA_W +: DATA_W]
//   commit_o                     one-cycle pulse, cycle after active updated
//   parity_err_o                 sticky parity error (only with the macro)
// -----------------------------------------------------------------------------
module falafel_config_regfile
  import falafel_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [DATA_W-1:0]          req_addr_i,
  input  logic [DATA_W-1:0]          req_wdata_i,
  input  logic [DATA_W/8-1:0]        req_wstrb_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  input  logic                       busy_i,
  output logic [NUM_REGS*DATA_W-1:0] cfg_o,
  output logic                       commit_o
`ifdef FALAFEL_CFG_PARITY_EN
  ,
  output logic                       parity_err_o
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(STRB_W - 1);
  localparam logic [DATA_W-1:0] NUM_IDX    = DATA_W'(NUM_REGS);
  localparam logic [DATA_W-1:0] COMMIT_IDX = DATA_W'(NUM_REGS + CFG_COMMIT_IDX);
  localparam logic [DATA_W-1:0] STATUS_IDX = DATA_W'(NUM_REGS + CFG_STATUS_IDX);

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];

  logic [DATA_W-1:0] idx;
  logic [IDX_W-1:0]  cfg_idx;
  cfg_req_t          dec;
  cfg_rsp_t          rsp_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] status_word;

  logic              accept;
  logic              cfg_wr;
  logic              commit_req;
  logic              apply;
  logic              pending;
  logic [CNT_W-1:0]  count;
  logic              parity_err;

  // ---------------------------------------------------------------------------
  // Handshake and address decode
  // ---------------------------------------------------------------------------
  assign req_ready_o = !rsp_q.valid || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case chain can leave a value held (no latch).
  always_comb begin
    idx        = req_addr_i >> OFS_W;
    dec.we     = req_we_i;
    dec.target = TGT_NONE;
    dec.err    = 1'b0;
    if ((req_addr_i & ALIGN_MASK) != '0) begin
      dec.err = 1'b1;
    end else if (idx < NUM_IDX) begin
      dec.target = TGT_CFG;
    end else if (idx == COMMIT_IDX) begin
      dec.target = TGT_COMMIT;
    end else if (idx == STATUS_IDX) begin
      dec.target = TGT_STATUS;
      dec.err    = req_we_i;
    end else begin
      dec.err = 1'b1;
    end
  end

  assign cfg_idx    = idx[IDX_W-1:0];
  assign cfg_wr     = accept && dec.we && !dec.err && (dec.target == TGT_CFG);
  assign commit_req = accept && dec.we && !dec.err && (dec.target == TGT_COMMIT);

  // ---------------------------------------------------------------------------
  // Commit sequencing
  // ---------------------------------------------------------------------------
  falafel_cfg_commit_ctrl #(
    .CNT_W (CNT_W)
  ) u_commit_ctrl (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .commit_req_i (commit_req),
    .busy_i       (busy_i),
    .apply_o      (apply),
    .pending_o    (pending),
    .count_o      (count),
    .commit_o     (commit_o)
  );

  // ---------------------------------------------------------------------------
  // Shadow and active register banks
  // ---------------------------------------------------------------------------
  // NOTE: both banks are reset explicitly: they drive the core directly and
  // reads must return 0 after reset, so they cannot be reset-free RAM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (cfg_wr) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (req_wstrb_i[b]) begin
            shadow_q[cfg_idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
          end
        end
      end
      // Apply copies the pre-edge shadow, so a write on the same edge lands
      // in shadow only and waits for the next commit.
      if (apply) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
    assign cfg_o[g*DATA_W +: DATA_W] = active_q[g];
  end

  // ---------------------------------------------------------------------------
  // Optional parity protection of the active bank
  // ---------------------------------------------------------------------------
`ifdef FALAFEL_CFG_PARITY_EN
  logic [NUM_REGS-1:0] parity_q;
  logic                parity_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      parity_q     <= '0;
      parity_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (apply) begin
          parity_q[i] <= ^shadow_q[i];
        end
        if ((^active_q[i]) != parity_q[i]) begin
          parity_err_q <= 1'b1;
        end
      end
    end
  end

  assign parity_err   = parity_err_q;
  assign parity_err_o = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux and registered response
  // ---------------------------------------------------------------------------
  always_comb begin
    status_word                                  = '0;
    status_word[STATUS_PENDING_BIT]              = pending;
    status_word[STATUS_PARITY_BIT]               = parity_err;
    status_word[STATUS_COUNT_LSB +: CNT_W]       = count;
  end

  always_comb begin
    rdata_d = '0;
    if (!dec.we && !dec.err) begin
      case (dec.target)
        TGT_CFG:    rdata_d = shadow_q[cfg_idx];
        TGT_STATUS: rdata_d = status_word;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q       <= '0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      rsp_q.valid <= 1'b1;
      rsp_q.err   <= dec.err;
      rsp_rdata_q <= rdata_d;
    end else if (rsp_ready_i) begin
      rsp_q.valid <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_q.valid;
  assign rsp_err_o   = rsp_q.err;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_falafel_config_regfile.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_falafel_config_regfile
//   Self-checking bench for falafel_config_regfile with its default
//   parameters. A behavioural model (shadow/active arrays, pending flag,
//   commit count) predicts every read, STATUS word and cfg_o value.
// -----------------------------------------------------------------------------
module tb_falafel_config_regfile;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 4;
  localparam int CNT_W    = 8;
  localparam int STRB_W   = DATA_W / 8;
  localparam logic [63:0] COMMIT_ADDR = 64'(NUM_REGS * STRB_W);
  localparam logic [63:0] STATUS_ADDR = 64'((NUM_REGS + 1) * STRB_W);

  logic                       clk_i;
  logic                       rst_i;
  logic                       req_valid_i;
  logic                       req_ready_o;
  logic                       req_we_i;
  logic [DATA_W-1:0]          req_addr_i;
  logic [DATA_W-1:0]          req_wdata_i;
  logic [STRB_W-1:0]          req_wstrb_i;
  logic                       rsp_valid_o;
  logic                       rsp_ready_i;
  logic [DATA_W-1:0]          rsp_rdata_o;
  logic                       rsp_err_o;
  logic                       busy_i;
  logic [NUM_REGS*DATA_W-1:0] cfg_o;
  logic                       commit_o;
`ifdef FALAFEL_CFG_PARITY_EN
  logic                       parity_err_o;
`endif

  falafel_config_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .busy_i      (busy_i),
    .cfg_o       (cfg_o),
    .commit_o    (commit_o)
`ifdef FALAFEL_CFG_PARITY_EN
    ,
    .parity_err_o (parity_err_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors;
  int miscompares;
  int pulse_cnt;

  // Reference model state.
  logic [63:0] shadow_m [NUM_REGS];
  logic [63:0] active_m [NUM_REGS];
  bit          pending_m;
  int          count_m;
  int          pulse_m;

  // Count commit pulses mid-cycle, away from the clock edge.
  always @(negedge clk_i) begin
    if (rst_i) pulse_cnt = 0;
    else if (commit_o === 1'b1) pulse_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_m[i] = '0;
      active_m[i] = '0;
    end
    pending_m = 0;
    count_m   = 0;
    pulse_m   = 0;
  endfunction

  function automatic void model_write(input int idx, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < STRB_W; b++)
      if (s[b]) shadow_m[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic void model_apply();
    for (int i = 0; i < NUM_REGS; i++) active_m[i] = shadow_m[i];
    pending_m = 0;
    count_m   = (count_m + 1) % (1 << CNT_W);
    pulse_m++;
  endfunction

  function automatic void model_commit(input logic busy);
    if (busy) pending_m = 1;
    else model_apply();
  endfunction

  function automatic logic [63:0] model_status();
    return (64'(count_m) << 8) | 64'(pending_m);
  endfunction

  function automatic logic [NUM_REGS*DATA_W-1:0] model_cfg();
    logic [NUM_REGS*DATA_W-1:0] r;
    for (int i = 0; i < NUM_REGS; i++) r[i*DATA_W +: DATA_W] = active_m[i];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus access: starts and ends 1 ns after a rising edge; returns the response
  // seen the cycle after acceptance (ok = 0 if no response was there).
  // ---------------------------------------------------------------------------
  task automatic bus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wstrb, output logic ok, output logic [63:0] rd,
                     output logic er);
    int n = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = wstrb;
    while (req_ready_o !== 1'b1 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    ok = (rsp_valid_o === 1'b1) && (n < 50);
    rd = rsp_rdata_o;
    er = rsp_err_o;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    busy_i      = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic ok; logic [63:0] rd; logic er;
    do_reset();
    vectors++;
    if ({rsp_valid_o, commit_o, req_ready_o} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, expected 001", {rsp_valid_o, commit_o, req_ready_o});
    end
    vectors++;
    if (cfg_o !== '0) begin
      miscompares++;
      $display("FAIL reset_cfg: got %h, expected 0", cfg_o);
    end
    bus(0, STATUS_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, model_status()}) begin
      miscompares++;
      $display("FAIL reset_status: got ok=%b err=%b %h, expected ok=1 err=0 %h", ok, er, rd, model_status());
    end
  endtask

  task automatic test_directed();
    logic ok; logic [63:0] rd; logic er;
    bus(1, 64'h0, 64'h1000, 8'hFF, ok, rd, er);
    model_write(0, 64'h1000, 8'hFF);
    bus(0, 64'h0, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, 64'h1000}) begin
      miscompares++;
      $display("FAIL dir_read0: got ok=%b err=%b %h, expected ok=1 err=0 1000", ok, er, rd);
    end
    vectors++;
    if (cfg_o[63:0] !== 64'h0) begin
      miscompares++;
      $display("FAIL dir_no_commit: got %h, expected 0", cfg_o[63:0]);
    end
    bus(1, 64'h8, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, ok, rd, er);
    model_write(1, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    bus(0, 64'h8, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, 64'h0000_0000_CCCC_DDDD}) begin
      miscompares++;
      $display("FAIL dir_strobe: got ok=%b err=%b %h, expected ok=1 err=0 00000000ccccdddd", ok, er, rd);
    end
  endtask

  task automatic test_random_rw();
    logic ok; logic [63:0] rd; logic er; logic [63:0] d; logic [7:0] s; int idx;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, NUM_REGS - 1);
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = 8'($urandom);
        bus(1, 64'(idx * STRB_W), d, s, ok, rd, er);
        model_write(idx, d, s);
        vectors++;
        if ({ok, er, rd} !== {2'b10, 64'h0}) begin
          miscompares++;
          $display("FAIL rnd_write[%0d]: got ok=%b err=%b %h, expected ok=1 err=0 0", i, ok, er, rd);
        end
      end else begin
        bus(0, 64'(idx * STRB_W), '0, '0, ok, rd, er);
        vectors++;
        if ({ok, er, rd} !== {2'b10, shadow_m[idx]}) begin
          miscompares++;
          $display("FAIL rnd_read[%0d] idx%0d: got ok=%b err=%b %h, expected ok=1 err=0 %h", i, idx, ok, er, rd, shadow_m[idx]);
        end
      end
    end
    vectors++;
    if (cfg_o !== model_cfg()) begin
      miscompares++;
      $display("FAIL rnd_cfg_held: got %h, expected %h", cfg_o, model_cfg());
    end
  endtask

  task automatic test_errors();
    logic ok; logic [63:0] rd; logic er;
    bus(0, 64'h4, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b11, 64'h0}) begin
      miscompares++;
      $display("FAIL err_misaligned: got ok=%b err=%b %h, expected ok=1 err=1 0", ok, er, rd);
    end
    bus(0, 64'((NUM_REGS + 2) * STRB_W), '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b11, 64'h0}) begin
      miscompares++;
      $display("FAIL err_unmapped: got ok=%b err=%b %h, expected ok=1 err=1 0", ok, er, rd);
    end
    bus(1, STATUS_ADDR, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, ok, rd, er);
    vectors++;
    if ({ok, er} !== 2'b11) begin
      miscompares++;
      $display("FAIL err_status_write: got ok=%b err=%b, expected ok=1 err=1", ok, er);
    end
    bus(0, STATUS_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, model_status()}) begin
      miscompares++;
      $display("FAIL err_status_kept: got %h, expected %h", rd, model_status());
    end
    bus(1, 64'h1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, ok, rd, er);
    vectors++;
    if ({ok, er} !== 2'b11) begin
      miscompares++;
      $display("FAIL err_misaligned_write: got ok=%b err=%b, expected ok=1 err=1", ok, er);
    end
    bus(0, 64'h0, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, shadow_m[0]}) begin
      miscompares++;
      $display("FAIL err_no_side_effect: got %h, expected %h", rd, shadow_m[0]);
    end
    bus(0, COMMIT_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, 64'h0}) begin
      miscompares++;
      $display("FAIL commit_read: got ok=%b err=%b %h, expected ok=1 err=0 0", ok, er, rd);
    end
  endtask

  task automatic test_commit_busy();
    logic ok; logic [63:0] rd; logic er;
    do_reset();
    busy_i = 1'b1;
    bus(1, COMMIT_ADDR, 64'h1234, 8'hFF, ok, rd, er);
    model_commit(1);
    bus(1, COMMIT_ADDR, 64'h5678, 8'hFF, ok, rd, er);
    model_commit(1);
    bus(1, 64'h10, 64'h7, 8'hFF, ok, rd, er);
    model_write(2, 64'h7, 8'hFF);
    bus(0, STATUS_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, model_status()}) begin
      miscompares++;
      $display("FAIL busy_pending: got %h, expected %h", rd, model_status());
    end
    vectors++;
    if (cfg_o !== model_cfg()) begin
      miscompares++;
      $display("FAIL busy_deferred: got %h, expected %h", cfg_o, model_cfg());
    end
    busy_i = 1'b0;
    @(posedge clk_i); #1;
    model_apply();
    vectors++;
    if ({commit_o, cfg_o[2*DATA_W +: DATA_W]} !== {1'b1, 64'h7}) begin
      miscompares++;
      $display("FAIL busy_apply: got pulse=%b entry2=%h, expected pulse=1 entry2=7", commit_o, cfg_o[2*DATA_W +: DATA_W]);
    end
    vectors++;
    if (cfg_o !== model_cfg()) begin
      miscompares++;
      $display("FAIL busy_cfg: got %h, expected %h", cfg_o, model_cfg());
    end
    @(posedge clk_i); #1;
    vectors++;
    if (commit_o !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_pulse_width: got %b, expected 0", commit_o);
    end
    bus(0, STATUS_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, model_status()} || rd[15:8] !== 8'd1) begin
      miscompares++;
      $display("FAIL busy_status_after: got %h, expected %h", rd, model_status());
    end
    vectors++;
    if (pulse_cnt !== pulse_m) begin
      miscompares++;
      $display("FAIL busy_pulse_count: got %0d, expected %0d", pulse_cnt, pulse_m);
    end
  endtask

  task automatic test_backpressure();
    logic ok; logic [63:0] rd; logic er; logic [63:0] held; logic [63:0] wd; logic [7:0] ws;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 64'(1 * STRB_W);
    @(posedge clk_i); #1;
    wd = {$urandom, $urandom};
    ws = 8'($urandom);
    req_we_i    = 1'b1;
    req_addr_i  = 64'(3 * STRB_W);
    req_wdata_i = wd;
    req_wstrb_i = ws;
    held = rsp_rdata_o;
    vectors++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, shadow_m[1]}) begin
      miscompares++;
      $display("FAIL bp_first: got v=%b err=%b %h, expected v=1 err=0 %h", rsp_valid_o, rsp_err_o, rsp_rdata_o, shadow_m[1]);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({req_ready_o, rsp_valid_o, rsp_rdata_o} !== {2'b01, held}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b %h, expected rdy=0 v=1 %h", c, req_ready_o, rsp_valid_o, rsp_rdata_o, held);
      end
      @(posedge clk_i); #1;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    model_write(3, wd, ws);
    vectors++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 64'h0}) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b err=%b %h, expected v=1 err=0 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    bus(0, 64'(3 * STRB_W), '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, shadow_m[3]}) begin
      miscompares++;
      $display("FAIL bp_write_landed: got %h, expected %h", rd, shadow_m[3]);
    end
  endtask

  task automatic test_random_commit();
    logic ok; logic [63:0] rd; logic er; logic [63:0] d; logic [7:0] s; int idx;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          idx = $urandom_range(0, NUM_REGS - 1);
          d = {$urandom, $urandom};
          s = 8'($urandom);
          bus(1, 64'(idx * STRB_W), d, s, ok, rd, er);
          model_write(idx, d, s);
        end
        2: begin
          bus(1, COMMIT_ADDR, {$urandom, $urandom}, 8'($urandom), ok, rd, er);
          model_commit(busy_i);
        end
        default: begin
          busy_i = 1'($urandom);
          @(posedge clk_i); #1;
          if (!busy_i && pending_m) model_apply();
        end
      endcase
      vectors++;
      if (cfg_o !== model_cfg()) begin
        miscompares++;
        $display("FAIL rc_cfg[%0d]: got %h, expected %h", i, cfg_o, model_cfg());
      end
    end
    busy_i = 1'b0;
    @(posedge clk_i); #1;
    if (pending_m) model_apply();
    bus(0, STATUS_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, model_status()}) begin
      miscompares++;
      $display("FAIL rc_status: got %h, expected %h", rd, model_status());
    end
    vectors++;
    if (pulse_cnt !== pulse_m || cfg_o !== model_cfg()) begin
      miscompares++;
      $display("FAIL rc_final: got pulses=%0d, expected %0d", pulse_cnt, pulse_m);
    end
  endtask

  task automatic test_wrap();
    logic ok; logic [63:0] rd; logic er;
    do_reset();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      bus(1, COMMIT_ADDR, '0, '0, ok, rd, er);
      model_commit(0);
    end
    bus(0, STATUS_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, model_status()} || rd[15:8] !== 8'hFF) begin
      miscompares++;
      $display("FAIL wrap_max: got %h, expected %h", rd, model_status());
    end
    bus(1, COMMIT_ADDR, '0, '0, ok, rd, er);
    model_commit(0);
    bus(0, STATUS_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, 64'h0}) begin
      miscompares++;
      $display("FAIL wrap_zero: got %h, expected 0", rd);
    end
    vectors++;
    if (pulse_cnt !== (1 << CNT_W)) begin
      miscompares++;
      $display("FAIL wrap_pulses: got %0d, expected %0d", pulse_cnt, 1 << CNT_W);
    end
  endtask

  task automatic test_reset_mid();
    logic ok; logic [63:0] rd; logic er; logic [63:0] d;
    d = {$urandom, $urandom} | 64'h1;
    bus(1, 64'h0, d, 8'hFF, ok, rd, er);
    model_write(0, d, 8'hFF);
    bus(1, COMMIT_ADDR, '0, '0, ok, rd, er);
    model_commit(0);
    busy_i = 1'b1;
    bus(1, COMMIT_ADDR, '0, '0, ok, rd, er);
    model_commit(1);
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 64'h0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    vectors++;
    if ({rsp_valid_o, cfg_o[63:0]} !== {1'b1, d}) begin
      miscompares++;
      $display("FAIL rm_pre: got v=%b entry0=%h, expected v=1 entry0=%h", rsp_valid_o, cfg_o[63:0], d);
    end
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if ({rsp_valid_o, commit_o, rsp_err_o, req_ready_o, rsp_rdata_o} !== {4'b0001, 64'h0}) begin
      miscompares++;
      $display("FAIL rm_outputs: got v=%b c=%b e=%b rdy=%b %h, expected 0 0 0 1 0", rsp_valid_o, commit_o, rsp_err_o, req_ready_o, rsp_rdata_o);
    end
    vectors++;
    if (cfg_o !== '0) begin
      miscompares++;
      $display("FAIL rm_cfg: got %h, expected 0", cfg_o);
    end
    rsp_ready_i = 1'b1;
    busy_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;
    model_reset();
    @(posedge clk_i); #1;
    bus(0, STATUS_ADDR, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd} !== {2'b10, 64'h0}) begin
      miscompares++;
      $display("FAIL rm_status: got %h, expected 0", rd);
    end
    bus(0, 64'h0, '0, '0, ok, rd, er);
    vectors++;
    if ({ok, er, rd, cfg_o} !== {2'b10, 64'h0, model_cfg()} || pulse_cnt !== 0) begin
      miscompares++;
      $display("FAIL rm_cleared: got shadow0=%h pulses=%0d, expected 0 0", rd, pulse_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    rsp_ready_i = 1'b1;
    busy_i      = 1'b0;
    model_reset();

    test_reset();
    test_directed();
    test_random_rw();
    test_errors();
    test_commit_busy();
    test_backpressure();
    test_random_commit();
    test_wrap();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
